// File: rtl/parc_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : parc_mem_arbiter                                                |
// | Brief    : Two-requester (imem/dmem) memory arbiter with in-order response |
// |            routing through a tag FIFO. Macro                               |
// |            PARC_MEM_ARBITER_DMEM_PRIORITY_EN selects fixed dmem priority;  |
// |            round-robin arbitration otherwise.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module parc_mem_arbiter #(
    parameter int p_max_outstanding = 4,
    parameter int p_addr_sz         = 32,
    parameter int p_data_sz         = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [p_addr_sz+p_data_sz+2:0]       imemreq_msg,
    input  logic                                 imemreq_val,
    output logic                                 imemreq_rdy,

    input  logic [p_addr_sz+p_data_sz+2:0]       dmemreq_msg,
    input  logic                                 dmemreq_val,
    output logic                                 dmemreq_rdy,

    output logic [p_addr_sz+p_data_sz+2:0]       memreq_msg,
    output logic                                 memreq_val,
    input  logic                                 memreq_rdy,

    input  logic [p_data_sz+2:0]                 memresp_msg,
    input  logic                                 memresp_val,

    output logic [p_data_sz+2:0]                 imemresp_msg,
    output logic                                 imemresp_val,
    output logic [p_data_sz+2:0]                 dmemresp_msg,
    output logic                                 dmemresp_val,

    output logic [$clog2(p_max_outstanding):0]   outstanding,
    output logic                                 resp_err
);

    localparam int   PTR_W   = $clog2(p_max_outstanding);
    localparam int   CNT_W   = PTR_W + 1;
    localparam logic ID_IMEM = 1'b0;
    localparam logic ID_DMEM = 1'b1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             tags_q [p_max_outstanding];
    logic             lock_vld_q;
    logic             lock_id_q;
    logic             last_grant_q;
    logic             resp_err_q;

    logic             full;
    logic             grant;
    logic             fire;
    logic             pop;
    logic             head_tag;
    logic             unexpected;

    // A locked side keeps the grant so its stalled message stays on the bus.
    always_comb begin
        grant = ID_IMEM;
        if (imemreq_val && dmemreq_val) begin
            if (lock_vld_q) begin
                grant = lock_id_q;
            end else begin
`ifdef PARC_MEM_ARBITER_DMEM_PRIORITY_EN
                grant = ID_DMEM;
`else
                grant = ~last_grant_q;
`endif
            end
        end else if (dmemreq_val) begin
            grant = ID_DMEM;
        end
    end

    assign full        = (count_q == CNT_W'(p_max_outstanding));
    assign memreq_val  = reset && !full && (imemreq_val || dmemreq_val);
    assign memreq_msg  = (grant == ID_DMEM) ? dmemreq_msg : imemreq_msg;
    assign fire        = memreq_val && memreq_rdy;
    assign imemreq_rdy = memreq_val && memreq_rdy && (grant == ID_IMEM);
    assign dmemreq_rdy = memreq_val && memreq_rdy && (grant == ID_DMEM);

    // count_q is held at zero during reset, so no response is routed then.
    assign pop          = memresp_val && (count_q != '0);
    assign unexpected   = memresp_val && (count_q == '0);
    assign head_tag     = tags_q[rd_ptr_q];
    assign imemresp_val = pop && (head_tag == ID_IMEM);
    assign dmemresp_val = pop && (head_tag == ID_DMEM);
    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;

    always_comb begin
        count_d = count_q;
        case ({fire, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= ID_IMEM;
            last_grant_q <= ID_DMEM;
            resp_err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (fire) begin
                wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
                last_grant_q <= grant;
                lock_vld_q   <= 1'b0;
            end else if (memreq_val) begin
                lock_vld_q <= 1'b1;
                lock_id_q  <= grant;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (unexpected) begin
                resp_err_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (fire) begin
            tags_q[wr_ptr_q] <= grant;
        end
    end

    assign outstanding = count_q;
    assign resp_err    = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_parc_mem_arbiter.sv
// Bench for parc_mem_arbiter (default round-robin build, depth 4): queue-based
// reference model checked every cycle plus directed literal expectations.
`default_nettype none

module tb_parc_mem_arbiter;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [66:0] imsg, dmsg, mmsg;
    logic        iv, dv, irdy, drdy, mval, mrdy;
    logic [34:0] rmsg, irmsg, drmsg;
    logic        rv, irv, drv;
    logic [2:0]  outst;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    parc_mem_arbiter #(
        .p_max_outstanding (N),
        .p_addr_sz         (32),
        .p_data_sz         (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_msg  (imsg),
        .imemreq_val  (iv),
        .imemreq_rdy  (irdy),
        .dmemreq_msg  (dmsg),
        .dmemreq_val  (dv),
        .dmemreq_rdy  (drdy),
        .memreq_msg   (mmsg),
        .memreq_val   (mval),
        .memreq_rdy   (mrdy),
        .memresp_msg  (rmsg),
        .memresp_val  (rv),
        .imemresp_msg (irmsg),
        .imemresp_val (irv),
        .dmemresp_msg (drmsg),
        .dmemresp_val (drv),
        .outstanding  (outst),
        .resp_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [66:0] mkreq(input logic t, input logic [31:0] a, input logic [31:0] d);
        return {t, a, 2'b00, d};
    endfunction

    function automatic logic [34:0] mkresp(input logic [31:0] d);
        return {1'b0, 2'b00, d};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-flight requests as a queue of requester ids (1 = dmem).
    bit tagq[$];
    bit m_err;
    bit m_last;
    bit m_hold;
    bit m_hold_id;

    function automatic bit exp_grant();
        if (iv && dv) return m_hold ? m_hold_id : !m_last;
        return dv ? 1'b1 : 1'b0;
    endfunction

    function automatic bit exp_val();
        return reset && (tagq.size() != N) && (iv || dv);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagq.delete();
            m_err     = 1'b0;
            m_last    = 1'b1;
            m_hold    = 1'b0;
            m_hold_id = 1'b0;
        end else begin : upd
            bit v, g, was_empty;
            v = exp_val();
            g = exp_grant();
            was_empty = (tagq.size() == 0);
            if (rv && was_empty) m_err = 1'b1;
            if (rv && !was_empty) void'(tagq.pop_front());
            if (v && mrdy) begin
                tagq.push_back(g);
                m_last = g;
                m_hold = 1'b0;
            end else if (v) begin
                m_hold    = 1'b1;
                m_hold_id = g;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit v, g, p, h;
        v = exp_val();
        g = exp_grant();
        p = reset && rv && (tagq.size() != 0);
        h = (tagq.size() != 0) ? tagq[0] : 1'b0;
        chk("cmp_memreq_val", mval, v);
        chk("cmp_imemreq_rdy", irdy, v && mrdy && !g);
        chk("cmp_dmemreq_rdy", drdy, v && mrdy && g);
        if (v) chk("cmp_memreq_msg", mmsg, g ? dmsg : imsg);
        chk("cmp_imemresp_val", irv, p && !h);
        chk("cmp_dmemresp_val", drv, p && h);
        chk("cmp_imemresp_msg", irmsg, rmsg);
        chk("cmp_dmemresp_msg", drmsg, rmsg);
        chk("cmp_outstanding", outst, tagq.size());
        chk("cmp_resp_err", err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        iv = 1'b1; dv = 1'b1; mrdy = 1'b1; rv = 1'b1;
        imsg = mkreq(1'b0, 32'h1000, 32'h0);
        dmsg = mkreq(1'b1, 32'h2000, 32'h55);
        rmsg = mkresp(32'h77);

        // Reset holds every valid/ready low even with active inputs
        tick();
        #1;
        chk("rst_memreq_val", mval, 1'b0);
        chk("rst_imemreq_rdy", irdy, 1'b0);
        chk("rst_dmemreq_rdy", drdy, 1'b0);
        chk("rst_imemresp_val", irv, 1'b0);
        chk("rst_outstanding", outst, 3'd0);
        chk("rst_resp_err", err, 1'b0);
        rv = 1'b0;
        reset = 1'b1;
        #1;

        // Round-robin under constant conflict: imem, dmem, imem, dmem
        for (int k = 0; k < 4; k++) begin
            rv = (k > 0);
            rmsg = mkresp(32'(k));
            #1;
            chk("rr_imem_rdy", irdy, (k % 2) == 0);
            chk("rr_dmem_rdy", drdy, (k % 2) == 1);
            if (k > 0) chk("rr_resp_to_imem", irv, (k % 2) == 1);
            tick();
        end
        iv = 1'b0; dv = 1'b0; rv = 1'b1;
        #1;
        chk("rr_last_resp_dmem", drv, 1'b1);
        tick();
        rv = 1'b0;
        #1;
        chk("rr_drained", outst, 3'd0);

        // Stalled dmem read holds the bus while imem joins
        mrdy = 1'b0;
        dv = 1'b1;
        dmsg = mkreq(1'b0, 32'h100, 32'h0);
        imsg = mkreq(1'b0, 32'h4000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) iv = 1'b1;
            if (k == 3) mrdy = 1'b1;
            #1;
            chk("lock_msg", mmsg, {1'b0, 32'h100, 2'b00, 32'h0});
            chk("lock_dmem_rdy", drdy, k == 3);
            chk("lock_imem_rdy", irdy, 1'b0);
            tick();
        end
        #1;
        chk("lock_next_imem", irdy, 1'b1);
        tick();
        iv = 1'b0; dv = 1'b0; rv = 1'b1;
        #1;
        chk("lock_resp_dmem", drv, 1'b1);
        tick();
        #1;
        chk("lock_resp_imem", irv, 1'b1);
        tick();
        rv = 1'b0;

        // Fill the tag FIFO: imem, dmem, dmem, imem
        for (int k = 0; k < 4; k++) begin
            iv = (k == 0 || k == 3);
            dv = (k == 1 || k == 2);
            tick();
        end
        iv = 1'b1; dv = 1'b1;
        #1;
        chk("full_outstanding", outst, 3'd4);
        chk("full_memreq_val", mval, 1'b0);
        chk("full_irdy", irdy, 1'b0);
        chk("full_drdy", drdy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rv = 1'b1;
            rmsg = mkresp(32'hA + 32'(k));
            #1;
            if (k == 0) chk("full_pop_still_blocked", irdy, 1'b0);
            chk("full_resp_imem", irv, (k == 0 || k == 3));
            chk("full_resp_dmem", drv, (k == 1 || k == 2));
            chk("full_resp_msg", irmsg, {3'b000, 32'hA + 32'(k)});
            tick();
            iv = 1'b0; dv = 1'b0;
        end
        rv = 1'b0;

        // Push and pop together at occupancy 1, pointers wrapping past entry 3
        dv = 1'b1; mrdy = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            iv = (k % 2) == 0;
            dv = (k % 2) == 1;
            rv = 1'b1;
            #1;
            chk("pp_resp_dmem", drv, (k % 2) == 0);
            tick();
            chk("pp_outstanding", outst, 3'd1);
        end
        iv = 1'b0; dv = 1'b0;
        #1;
        chk("pp_tail_dmem", drv, 1'b1);
        tick();
        rv = 1'b0;
        #1;
        chk("pp_drained", outst, 3'd0);

        // Response with nothing in flight
        rv = 1'b1;
        #1;
        chk("err_no_irv", irv, 1'b0);
        chk("err_no_drv", drv, 1'b0);
        tick();
        rv = 1'b0;
        tick(); tick(); tick();
        chk("err_sticky", err, 1'b1);
        chk("err_outstanding", outst, 3'd0);

        // Reset mid-operation with two imem requests in flight
        iv = 1'b1; mrdy = 1'b1;
        tick(); tick();
        iv = 1'b0;
        #1;
        chk("mid_outstanding_pre", outst, 3'd2);
        reset = 1'b0;
        #1;
        chk("mid_outstanding_async", outst, 3'd0);
        chk("mid_err_cleared", err, 1'b0);
        reset = 1'b1;
        iv = 1'b1; dv = 1'b1;
        #1;
        chk("mid_first_conflict_imem", irdy, 1'b1);
        tick();
        iv = 1'b0; dv = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        rv = 1'b1;
        #1;
        chk("mid_stale_resp_dropped", irv, 1'b0);
        tick();
        rv = 1'b0;
        #1;
        chk("mid_stale_resp_err", err, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
